hazard_src_pipe: RTL and testbench
==================================

Name: hazard_src_pipe

Overview:
- Three-stage pipeline tracker (ID, EX, MEM, then retire) that generates the hazard-condition flags consumed by the team's hazard control unit.
- It acts as the requesting side of that interface:
  - drives data / structural / control / branch-prediction / forwarding / correctness flags;
  - obeys the stall and flush responses it gets back.
- Used as the instruction-side source in pipeline-hazard demos and as a self-checking partner for the hazard unit.

Parameters:
- REG_W, 3, register-index width (register 0 is hard-wired zero, never a hazard source).
- CNT_W, 8, width of the saturating stall/flush event counters.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction offered to ID
- in_ready  output  1  ID accepts the instruction this cycle
- in_op  input  2  00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
- in_rd  input  REG_W  destination register (ignored for STORE/BRANCH)
- in_rs  input  REG_W  source register
- in_pred  input  1  branch predicted taken
- in_taken  input  1  actual branch outcome, carried with the instruction
- stall_i  input  1  stall response from hazard unit
- flush_i  input  1  flush response from hazard unit
- haz_data  output  1  RAW dependency pending for the instruction in ID
- haz_str  output  1  memory-port structural conflict
- haz_ctrl  output  1  branch in EX
- haz_branch  output  1  EX branch predicted taken
- haz_fwrd  output  1  pending RAW can be resolved by forwarding
- haz_crct  output  1  prediction correct, or no branch in EX
- retire_valid  output  1  instruction left MEM this cycle
- retire_rd  output  REG_W  its destination register
- stall_cnt  output  CNT_W  cycles with stall_i applied
- flush_cnt  output  CNT_W  cycles with flush_i applied

Behaviour:
- Interface: clock is clk; reset is asynchronous and active-low on rst_n.
- Reset state:
  - all stage valids 0;
  - haz_* = 0 except haz_crct = 1;
  - retire_valid 0, retire_rd 0;
  - counters 0;
  - in_ready 0 while rst_n low, 1 from the first cycle after release.
- Stage state: each stage register holds {valid, op, rd, rs, pred, taken}.
- A "writer" is a valid ALU or LOAD with rd != 0.
- Flags are combinational from registered stage state only. No input-to-flag paths.
  - haz_data = ID.valid & ID.rs != 0 & ((EX writer & EX.rd == ID.rs) | (MEM writer & MEM.rd == ID.rs)).
  - haz_fwrd = haz_data & !(EX.op == LOAD & EX writer & EX.rd == ID.rs). A load-use in EX is not forwardable.
  - haz_str = ID.valid & ID.op ∈ {LOAD, STORE} & MEM.valid & MEM.op ∈ {LOAD, STORE}.
  - haz_ctrl = EX.valid & EX.op == BRANCH.
  - haz_branch = haz_ctrl & EX.pred.
  - haz_crct = !haz_ctrl | (EX.pred == EX.taken).
- Advance with no stall and no flush:
  - ID ← input when in_valid & in_ready, else ID ← bubble;
  - EX ← ID; MEM ← EX; retire ← MEM.
- stall_i = 1 and flush_i = 0:
  - in_ready = 0 and ID holds;
  - EX ← bubble;
  - MEM and retire advance normally.
  - The stall persists as long as stall_i is held.
- flush_i = 1 (wins over stall_i):
  - ID ← bubble; in_ready = 0, so any offered instruction is not accepted;
  - EX advances into MEM; the branch completes;
  - EX ← bubble.
- in_ready = !stall_i & !flush_i & rst_n-released. It is combinational from stall_i/flush_i only.
- Retire: retire_valid/retire_rd are registered copies of MEM leaving, one cycle after MEM occupancy.
- Counters:
  - stall_cnt increments in each cycle with stall_i & !flush_i;
  - flush_cnt increments in each cycle with flush_i;
  - both saturate at 2^CNT_W - 1, with no wrap.
- Latency: an instruction accepted at edge N is in EX after edge N+1 and in MEM after N+2, and retires at edge N+3 (retire_valid high that cycle), absent stalls/flushes.
- Reset asserted mid-operation clears all stages immediately. In-flight instructions are lost and are not retired.

Test Plan:
- Control hazard, correct prediction: issue BRANCH pred=1 taken=1 → one cycle later haz_ctrl=1, haz_branch=1, haz_crct=1; no flush_i driven → branch retires 2 cycles later, flush_cnt=0.
- Control hazard, mispredict: BRANCH pred=1 taken=0 then ALU rd=2; drive flush_i while haz_ctrl=1, haz_crct=0 → ALU in ID discarded (no retire of rd=2), in_ready=0 that cycle, flush_cnt=1.
- RAW, forwardable: ALU rd=3, then ALU rs=3 → haz_data=1, haz_fwrd=1; no stall applied → both retire back-to-back (retire_rd 3 then 0).
- Load-use: LOAD rd=4, then ALU rs=4 → haz_data=1, haz_fwrd=0; stall_i for 1 cycle → ID held, EX bubble; next cycle haz_fwrd=1; stall_cnt=1.
- Structural: STORE, ALU rd=1, LOAD rd=5 issued consecutively → haz_str=1 when LOAD is in ID and STORE is in MEM; zero-source (rs=0) never raises haz_data.
- Reset/saturation: drive stall_i for 300 cycles → stall_cnt=255, in_ready=0 throughout; assert rst_n=0 mid-pipeline → all valids 0, haz_crct=1, counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_src_pipe.sv
// Purpose: ID/EX/MEM instruction tracker that raises hazard flags for the hazard control unit.
// Latency: accepted at edge N -> EX after N+1, MEM after N+2, retire_valid after N+3.
// Backpressure: in_ready drops for any stall_i/flush_i cycle; stall holds ID, flush empties ID and EX.
module hazard_src_pipe #(
    parameter int REG_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [REG_W-1:0] in_rd,
    input  logic [REG_W-1:0] in_rs,
    input  logic             in_pred,
    input  logic             in_taken,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             haz_data,
    output logic             haz_str,
    output logic             haz_ctrl,
    output logic             haz_branch,
    output logic             haz_fwrd,
    output logic             haz_crct,
    output logic             retire_valid,
    output logic [REG_W-1:0] retire_rd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] OP_ALU    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One pipeline stage worth of instruction state.
    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic             pred;
        logic             taken;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t id_q;
    stage_t ex_q;
    stage_t mem_q;
    stage_t in_stage;
    stage_t id_nxt;
    stage_t ex_nxt;

    // Set on the first clock edge after reset release; gates acceptance.
    logic run_q;
    logic stall_only;

    // A writer is a valid ALU or LOAD targeting a non-zero register.
    function automatic logic is_writer(input stage_t s);
        return s.valid && (s.op == OP_ALU || s.op == OP_LOAD) && (s.rd != '0);
    endfunction

    function automatic logic is_mem_op(input stage_t s);
        return s.valid && (s.op == OP_LOAD || s.op == OP_STORE);
    endfunction

    // Handshake: flush dominates stall; either one refuses new work.
    always_comb begin
        stall_only = stall_i & ~flush_i;
        in_ready   = run_q & ~stall_i & ~flush_i;
    end

    // Capture the offered instruction; rd is zeroed for ops that write nothing
    // so the writer test and retire_rd never see a stale destination.
    always_comb begin
        in_stage = BUBBLE;
        if (in_valid && in_ready) begin
            in_stage.valid = 1'b1;
            in_stage.op    = in_op;
            in_stage.rd    = (in_op == OP_ALU || in_op == OP_LOAD) ? in_rd : '0;
            in_stage.rs    = in_rs;
            in_stage.pred  = in_pred;
            in_stage.taken = in_taken;
        end
    end

    // Next-state for ID and EX; MEM always takes EX so a flushing branch completes.
    always_comb begin
        id_nxt = in_stage;
        ex_nxt = id_q;
        if (flush_i) begin
            id_nxt = BUBBLE;
            ex_nxt = BUBBLE;
        end else if (stall_only) begin
            id_nxt = id_q;
            ex_nxt = BUBBLE;
        end
    end

    // Pipeline stage registers and run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            id_q  <= BUBBLE;
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
        end else begin
            run_q <= 1'b1;
            id_q  <= id_nxt;
            ex_q  <= ex_nxt;
            mem_q <= ex_q;
        end
    end

    // Retire port: registered copy of whatever leaves MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid <= 1'b0;
            retire_rd    <= '0;
        end else begin
            retire_valid <= mem_q.valid;
            retire_rd    <= mem_q.valid ? mem_q.rd : '0;
        end
    end

    // Saturating event counters; flush cycles are never counted as stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_only && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_i && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Hazard flags decode registered stage state only, so no input reaches them.
    always_comb begin
        logic ex_hit;
        logic mem_hit;
        ex_hit     = is_writer(ex_q) && (ex_q.rd == id_q.rs);
        mem_hit    = is_writer(mem_q) && (mem_q.rd == id_q.rs);
        haz_data   = id_q.valid && (id_q.rs != '0) && (ex_hit || mem_hit);
        // A load still in EX has no data yet, so that dependency cannot be forwarded.
        haz_fwrd   = haz_data && !(ex_hit && ex_q.op == OP_LOAD);
        haz_str    = is_mem_op(id_q) && is_mem_op(mem_q);
        haz_ctrl   = ex_q.valid && (ex_q.op == OP_BRANCH);
        haz_branch = haz_ctrl && ex_q.pred;
        haz_crct   = !haz_ctrl || (ex_q.pred == ex_q.taken);
    end

endmodule

// File: tb/tb_hazard_src_pipe.sv
// Randomized plus directed bench for hazard_src_pipe with a retire scoreboard.
// Flags, in_ready and counters are checked every cycle against an instruction-level model.
// Retirements are predicted into a queue and popped by an independent monitor.
module tb_hazard_src_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs;
    logic       in_pred;
    logic       in_taken;
    logic       stall_i;
    logic       flush_i;
    logic       haz_data, haz_str, haz_ctrl, haz_branch, haz_fwrd, haz_crct;
    logic       retire_valid;
    logic [2:0] retire_rd;
    logic [7:0] stall_cnt;
    logic [7:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_src_pipe #(.REG_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
        .in_pred(in_pred), .in_taken(in_taken),
        .stall_i(stall_i), .flush_i(flush_i),
        .haz_data(haz_data), .haz_str(haz_str), .haz_ctrl(haz_ctrl),
        .haz_branch(haz_branch), .haz_fwrd(haz_fwrd), .haz_crct(haz_crct),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [1:0] op;
        bit [2:0] rd;
        bit [2:0] rs;
        bit       pred;
        bit       taken;
    } ins_t;

    // Model: pos[0]=ID, pos[1]=EX, pos[2]=MEM.
    ins_t pos [3];
    bit   m_run;
    int   m_stall;
    int   m_flush;
    int   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input ins_t e);
        return e.v && e.op <= 2'd1 && e.rd != 3'd0;
    endfunction

    function automatic bit memop(input ins_t e);
        return e.v && (e.op == 2'd1 || e.op == 2'd2);
    endfunction

    task automatic model_reset();
        ins_t z;
        z = '{default: 0};
        for (int i = 0; i < 3; i++) pos[i] = z;
        m_run   = 0;
        m_stall = 0;
        m_flush = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_haz_data", haz_data, 0);
        chk("rst_haz_str", haz_str, 0);
        chk("rst_haz_ctrl", haz_ctrl, 0);
        chk("rst_haz_branch", haz_branch, 0);
        chk("rst_haz_fwrd", haz_fwrd, 0);
        chk("rst_haz_crct", haz_crct, 1);
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_rd", retire_rd, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
    endtask

    // One clock: entered and left at posedge+1.
    task automatic step(input bit v, input bit [1:0] op, input bit [2:0] rd, input bit [2:0] rs,
                        input bit pred, input bit taken, input bit st, input bit fl);
        bit   e_data, e_fwrd, e_str, e_ctrl, e_rdy, acc, ex_hit, mem_hit;
        ins_t id, ex, mem, nw, z;
        in_valid = v; in_op = op; in_rd = rd; in_rs = rs;
        in_pred = pred; in_taken = taken; stall_i = st; flush_i = fl;
        id = pos[0]; ex = pos[1]; mem = pos[2];
        z = '{default: 0};
        ex_hit  = writes(ex) && ex.rd == id.rs;
        mem_hit = writes(mem) && mem.rd == id.rs;
        e_data  = id.v && id.rs != 0 && (ex_hit || mem_hit);
        e_fwrd  = e_data && !(ex_hit && ex.op == 2'd1);
        e_str   = memop(id) && memop(mem);
        e_ctrl  = ex.v && ex.op == 2'd3;
        e_rdy   = m_run && !st && !fl;
        @(negedge clk);
        chk("in_ready", in_ready, e_rdy);
        chk("haz_data", haz_data, e_data);
        chk("haz_fwrd", haz_fwrd, e_fwrd);
        chk("haz_str", haz_str, e_str);
        chk("haz_ctrl", haz_ctrl, e_ctrl);
        chk("haz_branch", haz_branch, e_ctrl && ex.pred);
        chk("haz_crct", haz_crct, !e_ctrl || ex.pred == ex.taken);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        acc = v && e_rdy;
        nw  = '{v: 1, op: op, rd: (op <= 2'd1) ? rd : 3'd0, rs: rs, pred: pred, taken: taken};
        if (mem.v) exp_q.push_back(int'(mem.rd));
        pos[2] = ex;
        if (fl) begin
            pos[1] = z;
            pos[0] = z;
            if (m_flush < 255) m_flush++;
        end else if (st) begin
            pos[1] = z;
            if (m_stall < 255) m_stall++;
        end else begin
            pos[1] = id;
            pos[0] = acc ? nw : z;
        end
        m_run = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Retire monitor: at most one entry is due per cycle, so queue occupancy says whether one is.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                chk("retire_valid", retire_valid, 1);
                chk("retire_rd", retire_rd, e);
            end else begin
                chk("retire_idle", retire_valid, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_op = 0; in_rd = 0; in_rs = 0;
        in_pred = 0; in_taken = 0; stall_i = 0; flush_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1;
        idle(2);

        // Branch predicted correctly.
        step(1, 3, 0, 0, 1, 1, 0, 0);
        idle(4);
        // Mispredict: flush while the branch sits in EX with an ALU behind it.
        step(1, 3, 0, 1, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0, 0, 0);
        step(1, 0, 6, 0, 0, 0, 0, 1);
        idle(4);
        // Forwardable RAW.
        step(1, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 0, 0);
        idle(4);
        // Load-use with one stall cycle.
        step(1, 1, 4, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4, 0, 0, 0, 0);
        step(1, 0, 7, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Structural: STORE, ALU, LOAD back to back; rs=0 everywhere.
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end
        idle(4);

        // Stall counter saturation with an instruction parked in ID.
        step(1, 0, 3, 2, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 4, 0, 0, 0, 1, 0);
        chk("stall_sat", stall_cnt, 255);

        // Asynchronous reset with the pipeline full.
        step(1, 1, 2, 0, 0, 0, 0, 0);
        step(1, 3, 0, 2, 1, 0, 0, 0);
        step(1, 2, 0, 2, 0, 0, 0, 0);
        rst_n = 0;
        #1;
        check_reset_values();
        model_reset();
        in_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        step(1, 0, 5, 0, 0, 0, 0, 0);
        step(1, 0, 6, 5, 0, 0, 0, 0);
        idle(5);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
